// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display scheduler.
package hex_display_pkg;

    // Scheduler FSM: waiting for a request, or showing a value for its hold time.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Width of the value presented to the 4-digit hex display driver.
    localparam int DISP_W = 16;

    // Hold counter width; it must be able to store HOLD_CYCLES-1.
    function automatic int cnt_width(input int hold_cycles);
        return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/hex_display_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// winner and wraps modulo N. Implemented as rotate, pick lowest, rotate back.
module rr_arbiter #(
    parameter int N = 4,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o
);

    logic [LW-1:0] start_s;
    logic [N-1:0]  rot_s;
    logic [N-1:0]  pick_s;

    // Rotate requests so the highest-priority source lands at bit 0, keep the
    // lowest set bit, then rotate that single bit back to its source position.
    always_comb begin
        start_s = (last_i == LW'(N - 1)) ? {LW{1'b0}} : (last_i + LW'(1));
        rot_s   = N'({req_i, req_i} >> start_s);
        pick_s  = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
        if (en_i) begin
            gnt_o = N'({pick_s, pick_s} >> (N - int'(start_s)));
        end else begin
            gnt_o = {N{1'b0}};
        end
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Shares one 16-bit hex display between NUM_SRC producers. Round-robin grant
// over a valid/ready handshake; every accepted value stays on the display for
// at least HOLD_CYCLES clocks before another source may take over.
module hex_display_scheduler
    import hex_display_pkg::*;
#(
    parameter int  NUM_SRC     = 4,
    parameter int  HOLD_CYCLES = 25_000_000,
    localparam int SRC_W       = $clog2(NUM_SRC),
    localparam int CNT_W       = cnt_width(HOLD_CYCLES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        req_valid,
    input  logic [DISP_W*NUM_SRC-1:0] req_data,
    output logic [NUM_SRC-1:0]        req_ready,
    output logic [DISP_W-1:0]         disp_data,
    output logic [SRC_W-1:0]          disp_src,
    output logic                      disp_busy
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DISP_W-1:0]   data_q, data_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [SRC_W-1:0]    last_q, last_d;
    logic                busy_q, busy_d;

    logic                eligible_s;
    logic [NUM_SRC-1:0]  gnt_s;
    logic [SRC_W-1:0]    gnt_idx_s;
    logic                xfer_s;

    // A grant is possible when idle or once the hold has fully elapsed; while
    // reset is asserted no grant is offered at all.
    always_comb begin
        eligible_s = rst_n && ((state_q == IDLE) || (cnt_q == {CNT_W{1'b0}}));
    end

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .en_i   (eligible_s),
        .gnt_o  (gnt_s)
    );

    // Encode the one-hot grant into a source index; a transfer happens
    // whenever any grant is issued because grants only go to valid sources.
    always_comb begin
        gnt_idx_s = {SRC_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            gnt_idx_s = gnt_idx_s | (gnt_s[i] ? SRC_W'(i) : {SRC_W{1'b0}});
        end
        xfer_s = |gnt_s;
    end

    // Next-state logic: load on transfer, count down the hold, fall back to
    // IDLE when the hold ends with nobody asking. Displayed value is retained.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (xfer_s) begin
            data_d  = req_data[DISP_W*gnt_idx_s +: DISP_W];
            src_d   = gnt_idx_s;
            last_d  = gnt_idx_s;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            state_d = HOLD;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                HOLD: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
        busy_d = (state_d == HOLD) && (cnt_d != {CNT_W{1'b0}});
    end

    // State, counter and display registers; reset clears the display at once
    // and gives source 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= {DISP_W{1'b0}};
            src_q   <= {SRC_W{1'b0}};
            last_q  <= SRC_W'(NUM_SRC - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready = gnt_s;
    assign disp_data = data_q;
    assign disp_src  = src_q;
    assign disp_busy = busy_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Randomized and directed bench for hex_display_scheduler (4 sources, hold 4).
module tb_hex_display_scheduler;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [16*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [15:0]   disp_data;
    logic [1:0]    disp_src;
    logic          disp_busy;

    hex_display_scheduler #(.NUM_SRC(N), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .disp_data (disp_data),
        .disp_src  (disp_src),
        .disp_busy (disp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: what is shown, who won last, and how many clocks the
    // current value has been on the display.
    logic [15:0] m_data;
    int          m_src;
    int          m_last;
    int          m_shown;
    int          cyc;
    int          grant_cyc[$];
    int          grant_src[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_data  = 16'h0000;
        m_src   = 0;
        m_last  = N - 1;
        m_shown = HOLD;
    endtask

    // Winner under the round-robin rule, or -1 if the display may not change.
    function automatic int model_grant(input logic [N-1:0] v);
        if (m_shown < HOLD) return -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check combinational grant and shown value,
    // then advance the model across the rising edge.
    task automatic step(input logic [N-1:0] v, input logic [16*N-1:0] d);
        int g;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        #1;
        g = model_grant(v);
        exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("disp_data", 32'(disp_data), 32'(m_data));
        check_eq("disp_src",  32'(disp_src),  32'(m_src));
        check_eq("disp_busy", 32'(disp_busy), 32'(m_shown < HOLD));
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            m_data  = d[16*g +: 16];
            m_src   = g;
            m_last  = g;
            m_shown = 1;
            grant_cyc.push_back(cyc);
            grant_src.push_back(g);
        end else if (m_shown < HOLD) begin
            m_shown++;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, {$urandom, $urandom});
    endtask

    initial begin
        logic [63:0] quad;
        cyc = 0;
        model_reset();
        quad = 64'h4444_3333_2222_1111;

        // 1: reset with every source asking
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = quad;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_data",  32'(disp_data), 32'h0);
        check_eq("rst_src",   32'(disp_src),  32'h0);
        check_eq("rst_busy",  32'(disp_busy), 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;

        // 2: single request from source 2
        step(4'b0100, 64'h0000_BEEF_0000_0000);
        idle_steps(6);
        check_eq("beef_kept", 32'(disp_data), 32'hBEEF);

        // 3: continuous requests from everyone, spacing must equal HOLD
        grant_cyc.delete();
        grant_src.delete();
        for (int i = 0; i < 20; i++) step(4'b1111, quad);
        for (int i = 1; i < grant_cyc.size(); i++) begin
            check_eq("spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'(HOLD));
        end
        check_eq("n_grants", 32'(grant_cyc.size()), 32'd5);
        idle_steps(4);

        // 4: wrap-around after source 3
        step(4'b1000, quad);
        idle_steps(3);
        grant_src.delete();
        for (int i = 0; i < 8; i++) step(4'b1010, quad);
        check_eq("wrap_first",  32'(grant_src[0]), 32'd1);
        check_eq("wrap_second", 32'(grant_src[1]), 32'd3);
        idle_steps(4);

        // 5: request during an active hold is held off
        step(4'b0001, 64'h0000_0000_0000_5A5A);
        step(4'b0000, quad);
        for (int i = 0; i < 4; i++) step(4'b0001, 64'h0000_0000_0000_1234);
        idle_steps(4);

        // 6: reset in the middle of a hold showing CAFE
        step(4'b0001, 64'h0000_0000_0000_CAFE);
        idle_steps(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_data",  32'(disp_data), 32'h0);
        check_eq("mid_rst_src",   32'(disp_src),  32'h0);
        check_eq("mid_rst_busy",  32'(disp_busy), 32'h0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        grant_src.delete();
        step(4'b1011, quad);
        check_eq("post_rst_src0", 32'(grant_src.size() > 0 ? grant_src[0] : -1), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
